// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles every bus signal of the two-requester memory port arbiter.
//   Requester 0 (instruction side, read only):
//     req0_valid, req0_addr            -> arbiter
//     req0_ready, req0_rdata           <- arbiter
//   Requester 1 (data side, read/write):
//     req1_valid, req1_we, req1_addr, req1_wdata -> arbiter
//     req1_ready, req1_rdata                     <- arbiter
//   Shared memory port:
//     mem_req, mem_we, mem_addr, mem_wdata <- arbiter
//     mem_done, mem_rdata                  -> arbiter
//   Status:
//     grant_sel (external 2:1 datapath mux select), busy <- arbiter
// Modports: slave = arbiter view, master = requester/memory-side view.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             req0_valid;
   logic [WIDTH-1:0] req0_addr;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_rdata;

   logic             req1_valid;
   logic             req1_we;
   logic [WIDTH-1:0] req1_addr;
   logic [WIDTH-1:0] req1_wdata;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_rdata;

   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_done;
   logic [WIDTH-1:0] mem_rdata;

   logic             grant_sel;
   logic             busy;

   modport slave (
      input  req0_valid, req0_addr,
      input  req1_valid, req1_we, req1_addr, req1_wdata,
      input  mem_done, mem_rdata,
      output req0_ready, req0_rdata,
      output req1_ready, req1_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata,
      output grant_sel, busy
   );

   modport master (
      output req0_valid, req0_addr,
      output req1_valid, req1_we, req1_addr, req1_wdata,
      output mem_done, mem_rdata,
      input  req0_ready, req0_rdata,
      input  req1_ready, req1_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata,
      input  grant_sel, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Arbitrates two requesters onto one shared memory port. A request seen in
// IDLE is latched, presented on the memory port until mem_done, and completed
// with a one-cycle ready pulse to the winner. All outputs are registered.
//
// Ports:
//   clk   - single clock, rising edge
//   rstn  - asynchronous active-low reset
//   bus   - mem_port_arbiter_if.slave (requester 0/1 handshakes, shared memory
//           port, grant_sel and busy status)
//
// Configuration macro:
//   MEM_ARB_ROUND_ROBIN_EN - when defined, ties in IDLE go to the requester
//                            not granted last (requester 0 wins the first tie).
//                            When undefined, requester 1 always wins ties.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rstn,
   mem_port_arbiter_if.slave bus
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] BUSY0 = 3'd1;
   localparam logic [2:0] BUSY1 = 3'd2;
   localparam logic [2:0] RESP0 = 3'd3;
   localparam logic [2:0] RESP1 = 3'd4;

   logic [2:0]       state_r;
   logic [2:0]       state_next_s;
   logic             any_valid_s;
   logic             pick1_s;

   logic             mem_req_r;
   logic             mem_we_r;
   logic [WIDTH-1:0] mem_addr_r;
   logic [WIDTH-1:0] mem_wdata_r;
   logic             req0_ready_r;
   logic             req1_ready_r;
   logic [WIDTH-1:0] req0_rdata_r;
   logic [WIDTH-1:0] req1_rdata_r;
   logic             grant_sel_r;
   logic             busy_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic             last_grant_r;
`endif

   assign any_valid_s = bus.req0_valid | bus.req1_valid;

   // Choose the winner among the currently valid requesters.
   always_comb begin
      pick1_s = 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      if (bus.req0_valid && bus.req1_valid) begin
         pick1_s = ~last_grant_r;
      end else if (bus.req1_valid) begin
         pick1_s = 1'b1;
      end else begin
         pick1_s = 1'b0;
      end
`else
      if (bus.req1_valid) begin
         pick1_s = 1'b1;
      end else begin
         pick1_s = 1'b0;
      end
`endif
   end

   // Next-state logic for the transaction FSM.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (any_valid_s) begin
               state_next_s = pick1_s ? BUSY1 : BUSY0;
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY0: begin
            if (bus.mem_done) begin
               state_next_s = RESP0;
            end else begin
               state_next_s = BUSY0;
            end
         end
         BUSY1: begin
            if (bus.mem_done) begin
               state_next_s = RESP1;
            end else begin
               state_next_s = BUSY1;
            end
         end
         RESP0:   state_next_s = IDLE;
         RESP1:   state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Registered outputs: request latch, memory port, ready pulses, read data.
   // The latch registers double as the memory port drivers, so the port is
   // immune to requester input changes while a transaction is in flight.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_req_r    <= 1'b0;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= {WIDTH{1'b0}};
         mem_wdata_r  <= {WIDTH{1'b0}};
         req0_ready_r <= 1'b0;
         req1_ready_r <= 1'b0;
         req0_rdata_r <= {WIDTH{1'b0}};
         req1_rdata_r <= {WIDTH{1'b0}};
         grant_sel_r  <= 1'b0;
         busy_r       <= 1'b0;
      end else begin
         req0_ready_r <= 1'b0;
         req1_ready_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (any_valid_s) begin
                  mem_req_r   <= 1'b1;
                  busy_r      <= 1'b1;
                  grant_sel_r <= pick1_s;
                  if (pick1_s) begin
                     mem_we_r    <= bus.req1_we;
                     mem_addr_r  <= bus.req1_addr;
                     mem_wdata_r <= bus.req1_wdata;
                  end else begin
                     mem_we_r    <= 1'b0;
                     mem_addr_r  <= bus.req0_addr;
                     mem_wdata_r <= {WIDTH{1'b0}};
                  end
               end else begin
                  mem_req_r <= 1'b0;
                  busy_r    <= 1'b0;
               end
            end
            BUSY0: begin
               if (bus.mem_done) begin
                  mem_req_r    <= 1'b0;
                  req0_ready_r <= 1'b1;
                  req0_rdata_r <= bus.mem_rdata;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            BUSY1: begin
               if (bus.mem_done) begin
                  mem_req_r    <= 1'b0;
                  req1_ready_r <= 1'b1;
                  req1_rdata_r <= bus.mem_rdata;
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            RESP0, RESP1: begin
               mem_req_r <= 1'b0;
               busy_r    <= 1'b0;
            end
            default: begin
               mem_req_r <= 1'b0;
               busy_r    <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_ARB_ROUND_ROBIN_EN
   // Remember the last granted requester; resets to 1 so requester 0 wins
   // the first tie.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         last_grant_r <= 1'b1;
      end else if ((state_r == IDLE) && any_valid_s) begin
         last_grant_r <= pick1_s;
      end else begin
         last_grant_r <= last_grant_r;
      end
   end
`endif

   assign bus.mem_req    = mem_req_r;
   assign bus.mem_we     = mem_we_r;
   assign bus.mem_addr   = mem_addr_r;
   assign bus.mem_wdata  = mem_wdata_r;
   assign bus.req0_ready = req0_ready_r;
   assign bus.req1_ready = req1_ready_r;
   assign bus.req0_rdata = req0_rdata_r;
   assign bus.req1_rdata = req1_rdata_r;
   assign bus.grant_sel  = grant_sel_r;
   assign bus.busy       = busy_r;

endmodule
